note_sequencer: RTL and testbench

//  Parametrised multi-channel tone sequencer: steps NUM_CH note-index patterns at a runtime tempo.

---
 rtl/note_seq_wr_if.sv | 28 ++
 rtl/note_sequencer.sv | 157 +++++++++++++++
 tb/tb_note_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/note_seq_wr_if.sv
// Table-load bus for note_sequencer: pattern writes and divider-table writes.
// pat_ch has one extra bit so an out-of-range channel can be presented and ignored.
interface note_seq_wr_if #(
  parameter int NUM_CH = 2,
  parameter int NOTE_W = 5,
  parameter int DIV_W  = 22,
  parameter int ADDR_W = 7
);
  localparam int CH_W = $clog2(NUM_CH + 1);

  logic              pat_we;
  logic [CH_W-1:0]   pat_ch;
  logic [ADDR_W-1:0] pat_addr;
  logic [NOTE_W-1:0] pat_data;
  logic              tbl_we;
  logic [NOTE_W-1:0] tbl_addr;
  logic [DIV_W-1:0]  tbl_data;

  modport master (
    output pat_we, pat_ch, pat_addr, pat_data,
    output tbl_we, tbl_addr, tbl_data
  );

  modport slave (
    input pat_we, pat_ch, pat_addr, pat_data,
    input tbl_we, tbl_addr, tbl_data
  );
endinterface

// File: rtl/note_sequencer.sv
// Multi-channel tone sequencer: steps per-channel note patterns at a runtime tempo and
// maps each note through a shared divider table to registered half-period dividers.
module note_sequencer #(
  parameter int NUM_CH  = 2,
  parameter int NOTE_W  = 5,
  parameter int DIV_W   = 22,
  parameter int ADDR_W  = 7,
  parameter int TEMPO_W = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       song_len,
  input  logic [TEMPO_W-1:0]      tempo_div,
  input  logic [NUM_CH-1:0]       mute,
  input  logic                    ovr_en,
  input  logic [NOTE_W-1:0]       ovr_note,
  note_seq_wr_if.slave            wr,
  output logic [NUM_CH*DIV_W-1:0] note_div,
  output logic [ADDR_W-1:0]       step,
  output logic                    playing,
  output logic                    done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TBL_N = 2 ** NOTE_W;
  localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    step_q, step_d;
  logic [TEMPO_W-1:0]   cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [NUM_CH*DIV_W-1:0] note_div_q, note_div_d;

  logic [NOTE_W-1:0]    pat_mem [NUM_CH][DEPTH];
  logic [DIV_W-1:0]     tbl_mem [TBL_N];

  logic [TEMPO_W-1:0]   tempo_last;
  logic                 tick;
  logic [CH_IW-1:0]     pat_ch_idx;
  logic                 pat_wr_ok;
  logic [NOTE_W-1:0]    sel_idx [NUM_CH];

  // ---------------------------------------------------------------------------
  // Pattern and divider storage
  // ---------------------------------------------------------------------------
  assign pat_ch_idx = wr.pat_ch[CH_IW-1:0];
  assign pat_wr_ok  = wr.pat_we && (int'(wr.pat_ch) < NUM_CH);

  // NOTE: storage arrays carry no reset; only control state is reset, so the
  // arrays map onto plain RAM and their contents are undefined until loaded.
  always_ff @(posedge clk) begin
    if (pat_wr_ok) begin
      pat_mem[pat_ch_idx][wr.pat_addr] <= wr.pat_data;
    end
    if (wr.tbl_we && (wr.tbl_addr != '0)) begin
      tbl_mem[wr.tbl_addr] <= wr.tbl_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM and tempo counter
  // ---------------------------------------------------------------------------
  assign tempo_last = (tempo_div == '0) ? '0 : tempo_div - TEMPO_W'(1);
  assign tick       = (state_q == ST_PLAY) && (cnt_q == tempo_last);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      step_d  = '0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = ST_PLAY;
      step_d  = '0;
      cnt_d   = '0;
    end else if (state_q == ST_PLAY) begin
      if (tick) begin
        cnt_d = '0;
        if (step_q == song_len) begin
          if (loop_en) begin
            step_d = '0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          // Wraps naturally through zero if song_len was lowered below step.
          step_d = step_q + ADDR_W'(1);
        end
      end else begin
        cnt_d = cnt_q + TEMPO_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output note selection: mute > override > pattern (only while playing)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel_idx[c] = '0;
      if (ovr_en) begin
        sel_idx[c] = ovr_note;
      end else if (state_q == ST_PLAY) begin
        sel_idx[c] = pat_mem[c][step_q];
      end
    end
  end

  always_comb begin
    note_div_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!mute[c] && (sel_idx[c] != '0)) begin
        note_div_d[c*DIV_W +: DIV_W] = tbl_mem[sel_idx[c]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      note_div_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      note_div_q <= note_div_d;
    end
  end

  assign note_div = note_div_q;
  assign step     = step_q;
  assign playing  = (state_q == ST_PLAY);
  assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: looping, one-shot, override/mute, fast tempo,
// start/stop priority, live pattern edits and asynchronous reset mid-playback.
module tb_note_sequencer;

  localparam int NUM_CH  = 2;
  localparam int NOTE_W  = 5;
  localparam int DIV_W   = 22;
  localparam int ADDR_W  = 7;
  localparam int TEMPO_W = 27;

  localparam logic [DIV_W-1:0] DIV3 = 22'd191571;
  localparam logic [DIV_W-1:0] DIV5 = 22'd1000;

  logic                    clk;
  logic                    rst_n;
  logic                    start, stop, loop_en, ovr_en;
  logic [ADDR_W-1:0]       song_len;
  logic [TEMPO_W-1:0]      tempo_div;
  logic [NUM_CH-1:0]       mute;
  logic [NOTE_W-1:0]       ovr_note;
  logic [NUM_CH*DIV_W-1:0] note_div;
  logic [ADDR_W-1:0]       step;
  logic                    playing, done;
  logic [DIV_W-1:0]        ch0, ch1;

  int n_vec = 0;
  int n_err = 0;

  note_seq_wr_if #(.NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .DIV_W(DIV_W), .ADDR_W(ADDR_W)) wr ();

  note_sequencer #(
    .NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .DIV_W(DIV_W), .ADDR_W(ADDR_W), .TEMPO_W(TEMPO_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .song_len (song_len),
    .tempo_div(tempo_div),
    .mute     (mute),
    .ovr_en   (ovr_en),
    .ovr_note (ovr_note),
    .wr       (wr.slave),
    .note_div (note_div),
    .step     (step),
    .playing  (playing),
    .done     (done)
  );

  assign ch0 = note_div[0 +: DIV_W];
  assign ch1 = note_div[DIV_W +: DIV_W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic pat_write(input int ch, input int addr, input int data);
    wr.pat_we   = 1'b1;
    wr.pat_ch   = 2'(ch);
    wr.pat_addr = ADDR_W'(addr);
    wr.pat_data = NOTE_W'(data);
    cyc(1);
    wr.pat_we   = 1'b0;
  endtask

  task automatic tbl_write(input int addr, input logic [DIV_W-1:0] data);
    wr.tbl_we   = 1'b1;
    wr.tbl_addr = NOTE_W'(addr);
    wr.tbl_data = data;
    cyc(1);
    wr.tbl_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_vec++; if (note_div !== '0) begin n_err++; $display("FAIL reset_note_div: got %0h want 0", note_div); end
    n_vec++; if (step !== '0) begin n_err++; $display("FAIL reset_step: got %0d want 0", step); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset_playing: got %0b want 0", playing); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic load_tables();
    tbl_write(3, DIV3);
    tbl_write(5, DIV5);
    tbl_write(0, 22'd77);
    pat_write(0, 0, 3);
    pat_write(0, 1, 0);
    pat_write(0, 2, 5);
    pat_write(0, 3, 3);
    pat_write(1, 0, 0);
    pat_write(1, 1, 5);
    pat_write(1, 2, 0);
    pat_write(1, 3, 0);
  endtask

  task automatic test_loop();
    song_len = 7'd1; tempo_div = 27'd4; loop_en = 1'b1;
    pulse_start();                                   // E0
    n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL loop_playing: got %0b want 1", playing); end
    n_vec++; if (step !== 7'd0) begin n_err++; $display("FAIL loop_step0: got %0d want 0", step); end
    cyc(1);                                          // E1
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL loop_ch0_s0: got %0d want %0d", ch0, DIV3); end
    n_vec++; if (ch1 !== '0) begin n_err++; $display("FAIL loop_ch1_s0: got %0d want 0", ch1); end
    cyc(3);                                          // E4
    n_vec++; if (step !== 7'd1) begin n_err++; $display("FAIL loop_step1: got %0d want 1", step); end
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL loop_ch0_lag: got %0d want %0d", ch0, DIV3); end
    cyc(1);                                          // E5
    n_vec++; if (ch0 !== '0) begin n_err++; $display("FAIL loop_ch0_s1: got %0d want 0", ch0); end
    n_vec++; if (ch1 !== DIV5) begin n_err++; $display("FAIL loop_ch1_s1: got %0d want %0d", ch1, DIV5); end
    cyc(3);                                          // E8
    n_vec++; if (step !== 7'd0) begin n_err++; $display("FAIL loop_wrap: got %0d want 0", step); end
    cyc(1);                                          // E9
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL loop_ch0_again: got %0d want %0d", ch0, DIV3); end
    pulse_stop();
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL stop_playing: got %0b want 0", playing); end
    cyc(1);
    n_vec++; if (note_div !== '0) begin n_err++; $display("FAIL stop_silence: got %0h want 0", note_div); end
  endtask

  task automatic test_reset_mid_play();
    pulse_start();                                   // E0
    cyc(5);                                          // E5: step 1, ch1 = DIV5
    n_vec++; if (ch1 !== DIV5) begin n_err++; $display("FAIL midrst_pre: got %0d want %0d", ch1, DIV5); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (note_div !== '0) begin n_err++; $display("FAIL midrst_note_div: got %0h want 0", note_div); end
    n_vec++; if (step !== '0) begin n_err++; $display("FAIL midrst_step: got %0d want 0", step); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL midrst_playing: got %0b want 0", playing); end
    cyc(2);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %0b want 0", done); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_one_shot();
    song_len = 7'd1; tempo_div = 27'd4; loop_en = 1'b0;
    pulse_start();                                   // E0
    cyc(7);                                          // E7
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL oneshot_early_done: got %0b want 0", done); end
    n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL oneshot_playing: got %0b want 1", playing); end
    cyc(1);                                          // E8
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL oneshot_done: got %0b want 1", done); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL oneshot_stopped: got %0b want 0", playing); end
    cyc(1);                                          // E9
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL oneshot_pulse_len: got %0b want 0", done); end
    n_vec++; if (note_div !== '0) begin n_err++; $display("FAIL oneshot_silent: got %0h want 0", note_div); end
    loop_en = 1'b1;
    pulse_start();                                   // replay E0
    n_vec++; if (step !== 7'd0 || playing !== 1'b1) begin n_err++; $display("FAIL replay_state: got step %0d playing %0b want 0/1", step, playing); end
    cyc(1);
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL replay_ch0: got %0d want %0d", ch0, DIV3); end
  endtask

  // Entered one edge after a restart, tempo 4, step 0.
  task automatic test_override();
    cyc(3);                                          // E4: step 1
    ovr_en = 1'b1; ovr_note = 5'd3; mute = 2'b10;
    cyc(1);                                          // E5
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL ovr_ch0: got %0d want %0d", ch0, DIV3); end
    n_vec++; if (ch1 !== '0) begin n_err++; $display("FAIL ovr_ch1_muted: got %0d want 0", ch1); end
    ovr_en = 1'b0; mute = 2'b00;
    cyc(1);                                          // E6: still step 1
    n_vec++; if (ch0 !== '0) begin n_err++; $display("FAIL ovr_release_ch0: got %0d want 0", ch0); end
    n_vec++; if (ch1 !== DIV5) begin n_err++; $display("FAIL ovr_release_ch1: got %0d want %0d", ch1, DIV5); end
    pulse_stop();
    ovr_en = 1'b1; ovr_note = 5'd5;
    cyc(1);
    n_vec++; if (ch0 !== DIV5 || ch1 !== DIV5) begin n_err++; $display("FAIL ovr_idle: got %0d/%0d want %0d/%0d", ch0, ch1, DIV5, DIV5); end
    ovr_en = 1'b0;
    cyc(1);
    n_vec++; if (note_div !== '0) begin n_err++; $display("FAIL ovr_idle_release: got %0h want 0", note_div); end
  endtask

  task automatic test_fast_tempo();
    logic [ADDR_W-1:0] exp_step [5];
    exp_step = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd0};
    song_len = 7'd3; tempo_div = 27'd0; loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (step !== exp_step[i]) begin n_err++; $display("FAIL fast_step%0d: got %0d want %0d", i, step, exp_step[i]); end
      if (i == 3) begin
        n_vec++; if (ch0 !== DIV5) begin n_err++; $display("FAIL fast_ch0_s2: got %0d want %0d", ch0, DIV5); end
      end
      cyc(1);
    end
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    n_vec++; if (playing !== 1'b0 || step !== '0) begin n_err++; $display("FAIL start_stop: got playing %0b step %0d want 0/0", playing, step); end
    cyc(2);
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL start_stop_hold: got %0b want 0", playing); end
  endtask

  task automatic test_pat_write();
    song_len = 7'd1; tempo_div = 27'd8; loop_en = 1'b1;
    pulse_start();                                   // E0
    cyc(1);                                          // E1
    n_vec++; if (ch0 !== DIV3) begin n_err++; $display("FAIL patwr_pre: got %0d want %0d", ch0, DIV3); end
    pat_write(0, 0, 5);                              // written at E2
    cyc(1);                                          // E3
    n_vec++; if (ch0 !== DIV5) begin n_err++; $display("FAIL patwr_live: got %0d want %0d", ch0, DIV5); end
    pat_write(2, 0, 3);                              // E4, out-of-range channel
    tbl_write(0, 22'd55);                            // E5, entry 0 is fixed
    cyc(2);                                          // E7, still step 0
    n_vec++; if (ch0 !== DIV5) begin n_err++; $display("FAIL patwr_badch_ch0: got %0d want %0d", ch0, DIV5); end
    n_vec++; if (ch1 !== '0) begin n_err++; $display("FAIL patwr_badch_ch1: got %0d want 0", ch1); end
    n_vec++; if (step !== 7'd0) begin n_err++; $display("FAIL patwr_step: got %0d want 0", step); end
    pulse_stop();
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; ovr_en = 1'b0;
    song_len = '0; tempo_div = '0; mute = '0; ovr_note = '0;
    wr.pat_we = 1'b0; wr.pat_ch = '0; wr.pat_addr = '0; wr.pat_data = '0;
    wr.tbl_we = 1'b0; wr.tbl_addr = '0; wr.tbl_data = '0;
    #1;
    test_reset();
    load_tables();
    test_loop();
    test_reset_mid_play();
    test_one_shot();
    test_override();
    test_fast_tempo();
    test_pat_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
